// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM state encoding,
// PC increment step and the default reset fetch address.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds the HALT state).
package instruction_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_REQ          = 2'd0;  // request driven at PC
  localparam fetch_state_t ST_WAIT_DISCARD = 2'd1;  // stale request outstanding
  localparam fetch_state_t ST_HOLD         = 2'd2;  // fetched word held for decode
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam fetch_state_t ST_HALT         = 2'd3;  // misaligned redirect seen
`endif

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// program_counter: PC register with reset load, redirect load and +4 step.
// Ports: clk_i, reset_i (sync, active-high), load_i/load_pc_i (redirect),
//        inc_i (advance by PC_INC, wraps mod 2^32), pc_o (current PC).
// Latency: new PC visible the cycle after load_i/inc_i; load wins over inc.
import instruction_fetch_pkg::*;

module program_counter #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: drives instruction-memory reads at PC, holds the fetched
// word for decode, and handles redirects (including ones that race a reply).
// Ports: clk_i, reset_i (sync, active-high); imem_req_o/imem_addr_o/imem_ack_i/
//        imem_rdata_i (memory); redirect_i/redirect_pc_i; instr_valid_o/
//        instruction_o/instr_pc_o/instr_ready_i (decode); fetch_err_o.
// Latency: ACK at edge n -> instr_valid_o in n+1; accept at edge m -> request in m+1.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect halts with
// fetch_err_o=1 until reset; otherwise redirect targets are word-aligned.
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        fetch_err_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_pc_q;
  logic [31:0]  stale_addr_q;
  logic [31:0]  pc;
  logic [31:0]  redirect_target;
  logic         pc_load, pc_inc, instr_load;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic redirect_bad;
  assign redirect_target = redirect_pc_i;
  assign redirect_bad    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign fetch_err_o     = (state_q == ST_HALT);
`else
  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign fetch_err_o     = 1'b0;
`endif

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (pc_load),
    .load_pc_i (redirect_target),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    instr_load = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          // Redirect beats a coincident ACK; without ACK the issued read
          // must still drain, so park in WAIT_DISCARD.
          pc_load = 1'b1;
          state_d = imem_ack_i ? ST_REQ : ST_WAIT_DISCARD;
        end else if (imem_ack_i) begin
          instr_load = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_WAIT_DISCARD: begin
        pc_load = redirect_i;
        if (imem_ack_i) begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        // A redirect discards the held word without advancing the PC.
        if (redirect_i) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (instr_ready_i) begin
          pc_inc  = 1'b1;
          state_d = ST_REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_REQ;
      end
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (redirect_bad && (state_q != ST_HALT)) begin
      state_d    = ST_HALT;
      pc_load    = 1'b0;
      instr_load = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_REQ;
      instr_q      <= 32'h0;
      instr_pc_q   <= 32'h0;
      stale_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      // Remember the address actually on the bus so WAIT_DISCARD keeps it
      // stable after the PC has moved to the redirect target.
      if (state_q == ST_REQ) begin
        stale_addr_q <= pc;
      end
      if (instr_load) begin
        instr_q    <= imem_rdata_i;
        instr_pc_q <= pc;
      end
    end
  end

  assign imem_req_o    = !reset_i &&
                         ((state_q == ST_REQ) || (state_q == ST_WAIT_DISCARD));
  assign imem_addr_o   = (state_q == ST_WAIT_DISCARD) ? stale_addr_q : pc;
  assign instr_valid_o = (state_q == ST_HOLD);
  assign instruction_o = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Port CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port RESET  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port IMEM_REQ  out  1  SHALL be the instruction-memory read request, held until acknowledged.
REQ-005 Port IMEM_ADDR  out  32  SHALL be the fetch address, stable while IMEM_REQ=1.
REQ-006 Port IMEM_ACK  in  1  SHALL be the memory response strobe, sampled only while a request is outstanding.
REQ-007 Port IMEM_RDATA  in  32  SHALL be the instruction word, valid when IMEM_ACK=1.
REQ-008 Port REDIRECT  in  1  SHALL be the branch/jump redirect strobe.
REQ-009 Port REDIRECT_PC  in  32  SHALL be the redirect target, sampled when REDIRECT=1.
REQ-010 Port INSTR_VALID  out  1  SHALL indicate INSTRUCTION/INSTR_PC hold a fetched word for decode and immediate extraction.
REQ-011 Port INSTRUCTION  out  32  SHALL be the registered fetched word.
REQ-012 Port INSTR_PC  out  32  SHALL be the address of INSTRUCTION.
REQ-013 Port INSTR_READY  in  1  SHALL indicate downstream accepts the word this cycle.
REQ-014 Port FETCH_ERR  out  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-015 FSM states SHALL be REQ (request driven), WAIT_DISCARD (stale request outstanding), HOLD (word held), HALT (error).
REQ-016 REQ: IMEM_REQ=1, IMEM_ADDR=PC; on IMEM_ACK, latch IMEM_RDATA into INSTRUCTION and PC into INSTR_PC, set INSTR_VALID=1 next cycle, go HOLD.
REQ-017 HOLD: IMEM_REQ=0; on INSTR_VALID&&INSTR_READY, PC<=PC+4 (mod 2^32 wrap), INSTR_VALID<=0, go REQ.
REQ-018 Minimum latency SHALL be: ACK at edge n -> INSTR_VALID=1 in cycle n+1; accept at edge m -> IMEM_REQ=1 in cycle m+1.
REQ-019 REDIRECT in REQ without ACK: PC<=REDIRECT_PC, go WAIT_DISCARD (issued request must still complete).
REQ-020 WAIT_DISCARD: IMEM_REQ=1 at old address; on ACK, drop data, go REQ with new PC; further REDIRECT here only updates PC.
REQ-021 REDIRECT coincident with ACK in REQ: redirect SHALL win, data dropped, PC<=REDIRECT_PC, next state REQ.
REQ-022 REDIRECT in HOLD (with or without INSTR_READY): INSTR_VALID<=0, PC<=REDIRECT_PC, go REQ; held word is not counted as consumed.
REQ-023 INSTRUCTION and INSTR_PC SHALL not change while INSTR_VALID=1.

Reset
REQ-024 During RESET: PC=RESET_PC, state REQ, IMEM_REQ=0, INSTR_VALID=0, FETCH_ERR=0, INSTRUCTION=0, INSTR_PC=0.
REQ-025 First cycle after RESET falls SHALL drive IMEM_REQ=1, IMEM_ADDR=RESET_PC.
REQ-026 RESET mid-request SHALL abandon the outstanding request; the memory tolerates abandoned requests.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN defined: REDIRECT with REDIRECT_PC[1:0]!=0 SHALL set FETCH_ERR=1, go HALT (IMEM_REQ=0, INSTR_VALID=0) until RESET.
REQ-028 Macro undefined: REDIRECT_PC[1:0] SHALL be forced to 0, FETCH_ERR tied 0, HALT absent.

Structure
REQ-029 Shared package SHALL hold FSM state typedef, PC increment constant (4), RESET_PC default.
REQ-030 One sub-module, program_counter (PC register, +4 increment, redirect mux, reset load), SHALL be used.

Verification
REQ-031 Reset release, RESET_PC=0x100, ACK 2 cycles later with 0x00500093, READY=1 -> INSTR_VALID with INSTRUCTION=0x00500093, INSTR_PC=0x100; next IMEM_ADDR=0x104.
REQ-032 READY=0 for 5 cycles in HOLD -> INSTRUCTION/INSTR_PC stable, IMEM_REQ=0 throughout.
REQ-033 REDIRECT to 0x200 while waiting at 0x104, ACK 3 cycles later -> data dropped, INSTR_VALID stays 0, next IMEM_ADDR=0x200.
REQ-034 REDIRECT to 0x300 same cycle as ACK -> no INSTR_VALID, next request at 0x300.
REQ-035 PC=0xFFFF_FFFC, word accepted -> next IMEM_ADDR=0x0000_0000.
REQ-036 With FETCH_MISALIGN_CHECK_EN, REDIRECT to 0x202 -> FETCH_ERR=1, IMEM_REQ=0 until RESET; without macro -> request at 0x200.
